hex_depth_resolve: RTL and testbench
====================================

# hex_depth_resolve

Downstream consumer of the hexagonal rasterizer. It takes the rasterizer's axial cell stream (q, r, depth, valid) and maps each cell into a bounded hexagonal grid. It holds a per-cell depth buffer and forwards only fragments that pass a nearer-wins depth test, through an output FIFO with a valid/ready handshake. The rasterizer has no backpressure, so this block absorbs one fragment per cycle and counts everything it must drop.

## Interface

Parameters:
- GRID_R, 7: grid radius. A cell is in the grid iff |q| ≤ GRID_R, |r| ≤ GRID_R and |q+r| ≤ GRID_R.
- FIFO_DEPTH, 8: output FIFO entries. Must be a power of two, ≥ 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  fragment present this cycle. Always accepted, never stalled.
- in_q  in  16 signed  axial q.
- in_r  in  16 signed  axial r.
- in_depth  in  8  fragment depth; smaller is nearer.
- clear  in  1  single-cycle request to reset every depth entry to 8'hFF.
- busy  out  1  clear sweep in progress.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_q  out  16 signed  head q.
- out_r  out  16 signed  head r.
- out_depth  out  8  head depth.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- drop_oob  out  16  saturating count of fragments dropped: outside the grid, or arriving while busy.
- drop_ovf  out  16  saturating count of fragments that passed the depth test but found the FIFO full.

## Operation

- Address mapping: addr = (r+GRID_R)·(2·GRID_R+1) + (q+GRID_R).
  - Storage is (2·GRID_R+1)² entries of 8 bits, 225 at the default.
  - Corner addresses that are not valid cells are never written by fragments.
- Pipeline stages:
  - S0 (input edge): bounds check and address computation. A synchronous read of the depth RAM is issued. The RAM is read-before-write.
  - S1: compare in_depth < stored, strictly less. On pass, write in_depth to the RAM and push (q, r, depth) to the FIFO.
- Bypass: if the S1 write address equals the address read in the same edge, the new S1 fragment uses the written depth, not the RAM output. Back-to-back fragments to one cell therefore see the previous winner.
- Equal depth fails. Stored 8'hFF means empty; a fragment with depth 8'hFF never passes.
- Drops:
  - An out-of-grid fragment, or any fragment while busy=1, increments drop_oob. It has no RAM or FIFO effect.
  - A passing fragment with the FIFO full and no simultaneous pop increments drop_ovf. Its RAM write still occurs.
- FSM states: CLEAR and IDLE.
  - Reset enters CLEAR with the address counter at 0.
  - CLEAR writes 8'hFF at the counter value and increments each cycle. After the last address it goes to IDLE.
  - In IDLE, clear=1 enters CLEAR on the next edge.
  - clear while in CLEAR is ignored; the sweep does not restart.
  - A fragment already in S1 when clear is taken completes normally against pre-clear data. The sweep then overwrites its write.
- FIFO: push and pop in the same cycle are both honoured, including when full. Pop on empty is a no-op.
- Counters saturate at 16'hFFFF. They are cleared only by reset, not by clear.

## Timing

- Reset values: out_valid=0, out_q=out_r=out_depth=0, fifo_level=0, drop_oob=drop_ovf=0, busy=1.
- busy stays high for exactly (2·GRID_R+1)² cycles after reset deasserts. reset asserted mid-sweep restarts the sweep at address 0.
- Latency: a fragment sampled at edge N is pushed at edge N+1. out_valid rises in the cycle after edge N+1 (2-cycle latency into an empty FIFO).
- A clear sampled at edge N: busy=1 from cycle N+1 for 225 cycles at the default. A fragment sampled at edge N is still processed.
- Throughput: 1 fragment per cycle sustained when out_ready=1.
- drop_oob and drop_ovf update on the same edge that makes the drop decision, N and N+1 respectively.

## Structure

- Shared package hex_pkg holds:
  - typedef hex_frag_t {logic signed [15:0] q, r; logic [7:0] depth;}
  - depth constant DEPTH_EMPTY = 8'hFF
  - helper function hex_in_grid(q, r, radius)
- Sub-module hex_frag_fifo: parameterized synchronous FIFO of hex_frag_t with push, pop, full, empty and level. It is reused by later stages.
- Depth RAM is inferred inline as a synchronous single-port read plus write array.

## Test plan

- After reset, wait 225 cycles. Feed (0,0,d=10) → out (0,0,10) two cycles later; drop counters stay 0.
- Feed (2,-1,d=50), then the next cycle (2,-1,d=40), then (2,-1,d=40) → outputs 50 and 40 only. Bypass is exercised: the third fragment fails on equal depth.
- Feed (8,0,5) and (4,4,5), both violating a bound at GRID_R=7 → drop_oob=2, no outputs.
- Hold out_ready=0 and stream 10 distinct passing cells → fifo_level=8, drop_ovf=2. Release out_ready → the 8 heads drain in order.
- Pulse clear, then feed (0,0,200) during busy and again after busy falls → the first drops (drop_oob+1), the second passes with depth 200.
- Assert reset at sweep address 100 → busy stays high for a full 225 cycles after release, and counters read 0.

Source files
------------

// File: rtl/hex_pkg.sv
// Shared types and helpers for the hexagonal fragment pipeline.
package hex_pkg;

  typedef struct packed {
    logic signed [15:0] q;
    logic signed [15:0] r;
    logic [7:0]         depth;
  } hex_frag_t;

  localparam logic [7:0] DEPTH_EMPTY = 8'hFF;

  // Axial cell lies inside a hexagon of the given radius.
  function automatic logic hex_in_grid(input logic signed [15:0] q,
                                       input logic signed [15:0] r,
                                       input int radius);
    int qi, ri, si;
    qi = int'(q);
    ri = int'(r);
    si = qi + ri;
    return (qi >= -radius) && (qi <= radius) &&
           (ri >= -radius) && (ri <= radius) &&
           (si >= -radius) && (si <= radius);
  endfunction

endpackage

// File: rtl/hex_frag_fifo.sv
// Synchronous FIFO of hex fragments; simultaneous push/pop allowed when full.
module hex_frag_fifo
  import hex_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  hex_frag_t     din,
  input  logic          pop,
  output hex_frag_t     dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  localparam int PW = $clog2(DEPTH);

  hex_frag_t       mem [DEPTH];
  logic [PW-1:0]   wp, rp;
  logic            push_ok, pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  // Head reads as zero when nothing is queued so outputs are clean after reset.
  assign dout    = empty ? '0 : mem[rp];

  // Entry storage, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      level <= level + LW'(push_ok) - LW'(pop_ok);
    end
  end

endmodule

// File: rtl/hex_depth_resolve.sv
// Hex-grid depth test: bounds/address in S0, nearer-wins compare in S1,
// winners queued into an output FIFO. Clear sweep restores empty depths.
module hex_depth_resolve
  import hex_pkg::*;
#(
  parameter int GRID_R     = 7,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic signed [15:0]             in_q,
  input  logic signed [15:0]             in_r,
  input  logic [7:0]                     in_depth,
  input  logic                           clear,
  output logic                           busy,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [15:0]             out_q,
  output logic signed [15:0]             out_r,
  output logic [7:0]                     out_depth,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic [15:0]                    drop_oob,
  output logic [15:0]                    drop_ovf
);
  localparam int SIDE    = 2 * GRID_R + 1;
  localparam int N_CELLS = SIDE * SIDE;
  localparam int AW      = $clog2(N_CELLS);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t          state;
  logic [AW-1:0]   sweep_addr;

  logic [7:0]      depth_ram [N_CELLS];

  logic            s0_in_grid, s0_take;
  logic [AW-1:0]   s0_addr;
  int              s0_addr_i;

  logic            s1_vld, s1_pass;
  hex_frag_t       s1_frag;
  logic [AW-1:0]   s1_addr;
  logic [7:0]      s1_stored;

  logic            ram_we;
  logic [AW-1:0]   ram_wa;
  logic [7:0]      ram_wd;

  hex_frag_t       head;
  logic            f_full, f_empty, f_pop, f_push;

  assign busy = (state == ST_CLEAR);

  // S0: bounds check and flattened address.
  always_comb begin
    s0_in_grid = hex_in_grid(in_q, in_r, GRID_R);
    s0_addr_i  = (int'(in_r) + GRID_R) * SIDE + (int'(in_q) + GRID_R);
    s0_addr    = AW'(s0_addr_i);
    s0_take    = in_valid && s0_in_grid && !busy;
  end

  // S1 decision and FIFO handshake.
  assign s1_pass = s1_vld && (s1_frag.depth < s1_stored);
  assign f_pop   = out_ready && !f_empty;
  assign f_push  = s1_pass;

  // Single RAM write port: the sweep owns it while clearing, and any S1
  // write it displaces would be overwritten by the sweep anyway.
  always_comb begin
    ram_we = 1'b0;
    ram_wa = s1_addr;
    ram_wd = s1_frag.depth;
    if (busy) begin
      ram_we = 1'b1;
      ram_wa = sweep_addr;
      ram_wd = DEPTH_EMPTY;
    end else if (s1_pass) begin
      ram_we = 1'b1;
    end
  end

  // Depth RAM write.
  always_ff @(posedge clk) begin
    if (ram_we) depth_ram[ram_wa] <= ram_wd;
  end

  // S0->S1 register with read-before-write RAM read and same-cell bypass.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld    <= 1'b0;
      s1_frag   <= '0;
      s1_addr   <= '0;
      s1_stored <= DEPTH_EMPTY;
    end else begin
      s1_vld    <= s0_take;
      s1_frag   <= '{q: in_q, r: in_r, depth: in_depth};
      s1_addr   <= s0_addr;
      s1_stored <= (s1_pass && s1_addr == s0_addr) ? s1_frag.depth
                                                   : depth_ram[s0_addr];
    end
  end

  // Clear-sweep FSM: reset or an idle clear starts a full sweep from 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_CLEAR;
      sweep_addr <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (sweep_addr == AW'(N_CELLS - 1)) state <= ST_IDLE;
          else sweep_addr <= sweep_addr + 1'b1;
        end
        default: begin
          if (clear) begin
            state      <= ST_CLEAR;
            sweep_addr <= '0;
          end
        end
      endcase
    end
  end

  // Saturating drop counters; cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_oob <= '0;
      drop_ovf <= '0;
    end else begin
      if (in_valid && (busy || !s0_in_grid) && drop_oob != 16'hFFFF)
        drop_oob <= drop_oob + 16'd1;
      if (s1_pass && f_full && !f_pop && drop_ovf != 16'hFFFF)
        drop_ovf <= drop_ovf + 16'd1;
    end
  end

  hex_frag_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (f_push),
    .din   (s1_frag),
    .pop   (f_pop),
    .dout  (head),
    .full  (f_full),
    .empty (f_empty),
    .level (fifo_level)
  );

  assign out_valid = !f_empty;
  assign out_q     = head.q;
  assign out_r     = head.r;
  assign out_depth = head.depth;

endmodule

// File: tb/tb_hex_depth_resolve.sv
// Directed bench for hex_depth_resolve at GRID_R=7, FIFO_DEPTH=8.
module tb_hex_depth_resolve;
  import hex_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic signed [15:0] in_q, in_r;
  logic [7:0]         in_depth;
  logic               clear;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_q, out_r;
  logic [7:0]         out_depth;
  logic [3:0]         fifo_level;
  logic [15:0]        drop_oob, drop_ovf;

  int checks = 0;
  int failures = 0;
  hex_frag_t popped [$];

  hex_depth_resolve #(.GRID_R(7), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_q(in_q), .in_r(in_r),
    .in_depth(in_depth), .clear(clear), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_q(out_q), .out_r(out_r), .out_depth(out_depth),
    .fifo_level(fifo_level), .drop_oob(drop_oob), .drop_ovf(drop_ovf)
  );

  always #5 clk = ~clk;

  // Record every accepted head, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready)
      popped.push_back('{q: out_q, r: out_r, depth: out_depth});
  end

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int q, input int r, input int d);
    in_valid = 1'b1;
    in_q     = 16'(q);
    in_r     = 16'(r);
    in_depth = 8'(d);
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Counts cycles until busy falls, bounded.
  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_pop(input string tag, input int idx, input int q,
                         input int r, input int d);
    if (idx >= popped.size()) begin
      chk({tag, "_present"}, popped.size(), idx + 1);
    end else begin
      chk({tag, "_q"}, popped[idx].q, q);
      chk({tag, "_r"}, popped[idx].r, r);
      chk({tag, "_d"}, {24'd0, popped[idx].depth}, d);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; in_q = '0; in_r = '0; in_depth = '0;
    clear = 1'b0; out_ready = 1'b1;
    repeat (3) tick();

    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_q", out_q, 0);
    chk("rst_out_depth", {24'd0, out_depth}, 0);
    chk("rst_level", {28'd0, fifo_level}, 0);
    chk("rst_oob", {16'd0, drop_oob}, 0);
    chk("rst_ovf", {16'd0, drop_ovf}, 0);
    chk("rst_busy", {31'd0, busy}, 1);

    reset = 1'b0;
    busy_len(n);
    chk("init_sweep_len", n, 225);

    // Single fragment, two-cycle latency.
    drive(0, 0, 10);
    idle(0);
    chk("lat_not_yet", {31'd0, out_valid}, 0);
    tick();
    chk("lat_valid", {31'd0, out_valid}, 1);
    chk("lat_depth", {24'd0, out_depth}, 10);
    idle(3);
    chk("t1_count", popped.size(), 1);
    chk_pop("t1", 0, 0, 0, 10);
    chk("t1_oob", {16'd0, drop_oob}, 0);

    // Back-to-back same cell: 50 wins, 40 wins via bypass, equal 40 loses.
    popped.delete();
    drive(2, -1, 50);
    drive(2, -1, 40);
    drive(2, -1, 40);
    idle(4);
    chk("t2_count", popped.size(), 2);
    chk_pop("t2a", 0, 2, -1, 50);
    chk_pop("t2b", 1, 2, -1, 40);

    // Out-of-grid fragments.
    popped.delete();
    drive(8, 0, 5);
    drive(4, 4, 5);
    idle(4);
    chk("t3_oob", {16'd0, drop_oob}, 2);
    chk("t3_count", popped.size(), 0);

    // Overflow with consumer stalled.
    popped.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) drive(i - 5, 3, 20 + i);
    idle(3);
    chk("t4_level", {28'd0, fifo_level}, 8);
    chk("t4_ovf", {16'd0, drop_ovf}, 2);
    chk("t4_valid", {31'd0, out_valid}, 1);
    out_ready = 1'b1;
    idle(12);
    chk("t4_count", popped.size(), 8);
    for (int i = 0; i < 8; i++) chk_pop("t4", i, i - 5, 3, 20 + i);
    chk("t4_level_end", {28'd0, fifo_level}, 0);

    // Clear: fragment during busy drops, after busy it sees empty depth.
    popped.delete();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_busy", {31'd0, busy}, 1);
    drive(0, 0, 200);
    in_valid = 1'b0;
    busy_len(n);
    chk("t5_sweep_len", n + 1, 225);
    chk("t5_oob", {16'd0, drop_oob}, 3);
    drive(0, 0, 200);
    idle(4);
    chk("t5_count", popped.size(), 1);
    chk_pop("t5", 0, 0, 0, 200);

    // Reset mid-sweep restarts from address 0 and zeroes counters.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (100) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_oob", {16'd0, drop_oob}, 0);
    chk("t6_ovf", {16'd0, drop_ovf}, 0);
    busy_len(n);
    chk("t6_sweep_len", n, 225);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
